// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a big-endian byte stream into 32-bit words, writes them
// to sequential instruction-memory addresses and releases the CPU once the XOR checksum matches.
//
// state  | meaning
// HDR_HI | waiting for word-count high byte
// HDR_LO | waiting for word-count low byte
// DATA   | assembling payload words, one write per 4 bytes
// CHECK  | waiting for checksum byte
// DONE   | image verified, CPU released (terminal)
// ERROR  | oversize count or checksum mismatch (terminal)
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHECK, DONE, ERROR} state_t;

  localparam logic [15:0]           MAX_N    = 16'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WL_ONE   = (ADDR_WIDTH + 1)'(1);

  state_t      state, state_nxt;
  logic [7:0]  count_hi;
  logic [15:0] count_n;
  logic [15:0] words_rem;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_reg;
  logic [7:0]  csum;
  logic        accept;

  assign count_n    = {count_hi, byte_in};
  assign accept     = byte_valid && byte_ready;
  assign cpu_run    = (state == DONE);
  assign load_error = (state == ERROR);

  // Next state uses byte_valid directly: byte_ready is always 1 in the states that advance.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b1;
    case (state)
      HDR_HI: if (byte_valid) state_nxt = HDR_LO;
      HDR_LO: begin
        if (byte_valid) begin
          if (count_n > MAX_N)       state_nxt = ERROR;
          else if (count_n == 16'd0) state_nxt = CHECK;
          else                       state_nxt = DATA;
        end
      end
      DATA: begin
        if (byte_valid && byte_cnt == 2'd3 && words_rem == 16'd1) state_nxt = CHECK;
      end
      CHECK: begin
        if (byte_valid) state_nxt = (byte_in == csum) ? DONE : ERROR;
      end
      DONE, ERROR: byte_ready = 1'b0;
      default: state_nxt = HDR_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HDR_HI;
      count_hi     <= '0;
      words_rem    <= '0;
      byte_cnt     <= '0;
      asm_reg      <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      state   <= state_nxt;
      imem_we <= 1'b0;
      if (imem_we) imem_addr <= imem_addr + ADDR_ONE;
      if (accept) begin
        csum <= csum ^ byte_in;
        case (state)
          HDR_HI: count_hi  <= byte_in;
          HDR_LO: words_rem <= count_n;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_wdata   <= {asm_reg, byte_in};
              imem_we      <= 1'b1;
              words_loaded <= words_loaded + WL_ONE;
              words_rem    <= words_rem - 16'd1;
            end else begin
              asm_reg <= {asm_reg[15:0], byte_in};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: nominal, empty, oversize,
// bad checksum, handshake gaps, mid-load reset and full-size images.
module tb_imem_boot_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_wl[$];
  int          wr_cyc[$];
  int          acc_cyc[$];

  byte_q_t nominal = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                       8'h20, 8'h09, 8'h00, 8'h0A, 8'h0C};

  imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_run(cpu_run), .load_error(load_error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_wl.push_back(int'(words_loaded));
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_wl.delete(); wr_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  // Returns at negedge+1 of the cycle after the last byte was accepted.
  task automatic drive_stream(input byte_q_t s, input int gap_pct);
    int i = 0;
    int guard = 0;
    while (i < s.size() && guard < 20000) begin
      @(negedge clk); #1;
      guard++;
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        byte_valid = 1'b0;
      end else begin
        byte_in    = s[i];
        byte_valid = 1'b1;
        checks++;
        if (byte_ready !== 1'b1) begin
          errors++;
          $display("FAIL stall: byte_ready=%b required 1 at byte %0d", byte_ready, i);
          byte_valid = 1'b0;
        end else begin
          acc_cyc.push_back(cyc);
        end
        i++;
      end
    end
    checks++;
    if (i != s.size()) begin
      errors++;
      $display("FAIL stream_bound: sent %0d bytes required %0d", i, s.size());
    end
    @(negedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (byte_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready: got %b want 1", byte_ready); end
    if (imem_we !== 1'b0)       begin errors++; $display("FAIL rst_we: got %b want 0", imem_we); end
    if (cpu_run !== 1'b0)       begin errors++; $display("FAIL rst_run: got %b want 0", cpu_run); end
    if (load_error !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b want 0", load_error); end
    if (imem_addr !== 8'd0)     begin errors++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
    if (imem_wdata !== 32'd0)   begin errors++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
    if (words_loaded !== 9'd0)  begin errors++; $display("FAIL rst_wl: got %0d want 0", words_loaded); end
  endtask

  task automatic test_nominal();
    do_reset();
    drive_stream(nominal, 0);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL nom_count: got %0d writes want 2", wr_addr.size());
    end else begin
      checks += 8;
      if (wr_addr[0] != 0)               begin errors++; $display("FAIL nom_addr0: got %0d want 0", wr_addr[0]); end
      if (wr_data[0] !== 32'h20080005)   begin errors++; $display("FAIL nom_data0: got %h want 20080005", wr_data[0]); end
      if (wr_wl[0] != 1)                 begin errors++; $display("FAIL nom_wl0: got %0d want 1", wr_wl[0]); end
      if (wr_cyc[0] != acc_cyc[5] + 1)   begin errors++; $display("FAIL nom_lat0: got cyc %0d want %0d", wr_cyc[0], acc_cyc[5] + 1); end
      if (wr_addr[1] != 1)               begin errors++; $display("FAIL nom_addr1: got %0d want 1", wr_addr[1]); end
      if (wr_data[1] !== 32'h2009000A)   begin errors++; $display("FAIL nom_data1: got %h want 2009000a", wr_data[1]); end
      if (wr_wl[1] != 2)                 begin errors++; $display("FAIL nom_wl1: got %0d want 2", wr_wl[1]); end
      if (wr_cyc[1] != acc_cyc[9] + 1)   begin errors++; $display("FAIL nom_lat1: got cyc %0d want %0d", wr_cyc[1], acc_cyc[9] + 1); end
    end
    checks += 5;
    if (cpu_run !== 1'b1)       begin errors++; $display("FAIL nom_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)    begin errors++; $display("FAIL nom_err: got %b want 0", load_error); end
    if (words_loaded !== 9'd2)  begin errors++; $display("FAIL nom_wl: got %0d want 2", words_loaded); end
    if (byte_ready !== 1'b0)    begin errors++; $display("FAIL nom_ready: got %b want 0", byte_ready); end
    if (imem_addr !== 8'd2)     begin errors++; $display("FAIL nom_addr_end: got %0d want 2", imem_addr); end
  endtask

  task automatic test_empty();
    byte_q_t hdr = '{8'h00, 8'h00};
    byte_q_t ck  = '{8'h00};
    do_reset();
    drive_stream(hdr, 0);
    checks += 2;
    if (cpu_run !== 1'b0)    begin errors++; $display("FAIL empty_run_early: got %b want 0", cpu_run); end
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL empty_ready_check: got %b want 1", byte_ready); end
    drive_stream(ck, 0);
    checks += 4;
    if (cpu_run !== 1'b1)        begin errors++; $display("FAIL empty_run: got %b want 1", cpu_run); end
    if (byte_ready !== 1'b0)     begin errors++; $display("FAIL empty_ready: got %b want 0", byte_ready); end
    if (load_error !== 1'b0)     begin errors++; $display("FAIL empty_err: got %b want 0", load_error); end
    if (wr_addr.size() != 0)     begin errors++; $display("FAIL empty_writes: got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_oversize();
    byte_q_t hdr = '{8'h01, 8'h01};
    do_reset();
    drive_stream(hdr, 0);
    checks += 3;
    if (load_error !== 1'b1) begin errors++; $display("FAIL over_err: got %b want 1", load_error); end
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL over_ready: got %b want 0", byte_ready); end
    if (cpu_run !== 1'b0)    begin errors++; $display("FAIL over_run: got %b want 0", cpu_run); end
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    byte_valid = 1'b0;
    checks += 4;
    if (load_error !== 1'b1)    begin errors++; $display("FAIL over_err_hold: got %b want 1", load_error); end
    if (cpu_run !== 1'b0)       begin errors++; $display("FAIL over_run_hold: got %b want 0", cpu_run); end
    if (wr_addr.size() != 0)    begin errors++; $display("FAIL over_writes: got %0d want 0", wr_addr.size()); end
    if (words_loaded !== 9'd0)  begin errors++; $display("FAIL over_wl: got %0d want 0", words_loaded); end
  endtask

  task automatic test_bad_checksum();
    byte_q_t s = nominal;
    s[10] = 8'h0D;
    do_reset();
    drive_stream(s, 0);
    repeat (3) @(negedge clk);
    #1;
    checks += 5;
    if (wr_addr.size() != 2)    begin errors++; $display("FAIL bad_writes: got %0d want 2", wr_addr.size()); end
    if (words_loaded !== 9'd2)  begin errors++; $display("FAIL bad_wl: got %0d want 2", words_loaded); end
    if (load_error !== 1'b1)    begin errors++; $display("FAIL bad_err: got %b want 1", load_error); end
    if (cpu_run !== 1'b0)       begin errors++; $display("FAIL bad_run: got %b want 0", cpu_run); end
    if (byte_ready !== 1'b0)    begin errors++; $display("FAIL bad_ready: got %b want 0", byte_ready); end
  endtask

  task automatic test_gaps();
    do_reset();
    drive_stream(nominal, 40);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL gap_count: got %0d writes want 2", wr_addr.size());
    end else begin
      checks += 4;
      if (wr_addr[0] != 0)             begin errors++; $display("FAIL gap_addr0: got %0d want 0", wr_addr[0]); end
      if (wr_data[0] !== 32'h20080005) begin errors++; $display("FAIL gap_data0: got %h want 20080005", wr_data[0]); end
      if (wr_addr[1] != 1)             begin errors++; $display("FAIL gap_addr1: got %0d want 1", wr_addr[1]); end
      if (wr_data[1] !== 32'h2009000A) begin errors++; $display("FAIL gap_data1: got %h want 2009000a", wr_data[1]); end
    end
    checks += 3;
    if (cpu_run !== 1'b1)      begin errors++; $display("FAIL gap_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)   begin errors++; $display("FAIL gap_err: got %b want 0", load_error); end
    if (words_loaded !== 9'd2) begin errors++; $display("FAIL gap_wl: got %0d want 2", words_loaded); end
  endtask

  task automatic test_mid_reset();
    byte_q_t first5 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    do_reset();
    drive_stream(first5, 0);
    // sixth byte completes word 0 but coincides with reset, which must win
    byte_in    = 8'h05;
    byte_valid = 1'b1;
    reset      = 1'b1;
    @(negedge clk); #1;
    reset      = 1'b0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks += 5;
    if (wr_addr.size() != 0)    begin errors++; $display("FAIL mrst_writes: got %0d want 0", wr_addr.size()); end
    if (words_loaded !== 9'd0)  begin errors++; $display("FAIL mrst_wl: got %0d want 0", words_loaded); end
    if (imem_wdata !== 32'd0)   begin errors++; $display("FAIL mrst_wdata: got %h want 0", imem_wdata); end
    if (byte_ready !== 1'b1)    begin errors++; $display("FAIL mrst_ready: got %b want 1", byte_ready); end
    if (cpu_run !== 1'b0)       begin errors++; $display("FAIL mrst_run: got %b want 0", cpu_run); end
    clear_log();
    drive_stream(nominal, 0);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL mrst_count: got %0d writes want 2", wr_addr.size());
    end else begin
      checks += 4;
      if (wr_addr[0] != 0)             begin errors++; $display("FAIL mrst_addr0: got %0d want 0", wr_addr[0]); end
      if (wr_data[0] !== 32'h20080005) begin errors++; $display("FAIL mrst_data0: got %h want 20080005", wr_data[0]); end
      if (wr_addr[1] != 1)             begin errors++; $display("FAIL mrst_addr1: got %0d want 1", wr_addr[1]); end
      if (wr_data[1] !== 32'h2009000A) begin errors++; $display("FAIL mrst_data1: got %h want 2009000a", wr_data[1]); end
    end
    checks += 2;
    if (cpu_run !== 1'b1)      begin errors++; $display("FAIL mrst_run_after: got %b want 1", cpu_run); end
    if (words_loaded !== 9'd2) begin errors++; $display("FAIL mrst_wl_after: got %0d want 2", words_loaded); end
  endtask

  task automatic test_full_size();
    byte_q_t s;
    logic [7:0] kb;
    int bad = 0;
    s.push_back(8'h01);
    s.push_back(8'h00);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      repeat (4) s.push_back(kb);
    end
    // four equal bytes cancel, leaving only the header XOR
    s.push_back(8'h01);
    do_reset();
    drive_stream(s, 0);
    checks++;
    if (wr_addr.size() != 256) begin
      errors++; $display("FAIL full_count: got %0d writes want 256", wr_addr.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (wr_addr[k] != k || wr_data[k] !== 32'(k) * 32'h01010101 || wr_wl[k] != k + 1) begin
          errors++;
          if (bad < 4)
            $display("FAIL full_word%0d: got addr %0d data %h wl %0d want addr %0d data %h wl %0d",
                     k, wr_addr[k], wr_data[k], wr_wl[k], k, 32'(k) * 32'h01010101, k + 1);
          bad++;
        end
      end
    end
    checks += 3;
    if (words_loaded !== 9'd256) begin errors++; $display("FAIL full_wl: got %0d want 256", words_loaded); end
    if (cpu_run !== 1'b1)        begin errors++; $display("FAIL full_run: got %b want 1", cpu_run); end
    if (load_error !== 1'b0)     begin errors++; $display("FAIL full_err: got %b want 0", load_error); end
  endtask

  initial begin
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    test_reset();
    test_nominal();
    test_empty();
    test_oversize();
    test_bad_checksum();
    test_gaps();
    test_mid_reset();
    test_full_size();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
